// File: rtl/alu_share_arbiter.sv
// Purpose: shares one ALU + ALU control path between requester 0 (integer datapath) and requester 1 (address/branch helper).
// Latency: accept at T, ALU driven at T+1, rsp_valid from T+2; a new accept may overlap the response handshake.
// Backpressure: rsp_ready low holds the response and blocks all new accepts.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention instead of round-robin.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [11:0]      req0_op,
  input  logic [11:0]      req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_aluop,
  output logic [6:0]       alu_fun7,
  output logic [2:0]       alu_fun3,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic             rsp_done;
  logic             accept_ok;
  logic             accept;
  logic             grant;
  logic [11:0]      sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // The response handshake frees the ALU in the same cycle, so a new accept may overlap it.
  assign rsp_done  = (state == RESP) && rsp_ready[owner];
  assign accept_ok = (state == IDLE) || rsp_done;
  assign accept    = accept_ok && (req_valid != 2'b00);

  // Pick the winner among valid requesters; contention resolved by round-robin or fixed priority.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   grant = 1'b0;
`else
      2'b11:   grant = ~last_grant;
`endif
      default: grant = 1'b0;
    endcase
  end

  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign sel_op    = grant ? req1_op : req0_op;
  assign sel_a     = grant ? req1_a  : req0_a;
  assign sel_b     = grant ? req1_b  : req0_b;

  // Control FSM; ALU drive registers double as the latched operation and are only non-zero in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_aluop  <= 2'b00;
      alu_fun7   <= 7'd0;
      alu_fun3   <= 3'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Accept can only fire in IDLE or on the RESP handshake, never while EXEC drives the ALU.
      if (accept) begin
        owner                            <= grant;
        last_grant                       <= grant;
        {alu_aluop, alu_fun7, alu_fun3}  <= sel_op;
        alu_a                            <= sel_a;
        alu_b                            <= sel_b;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          alu_aluop  <= 2'b00;
          alu_fun7   <= 7'd0;
          alu_fun3   <= 3'd0;
          alu_a      <= '0;
          alu_b      <= '0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid <= 2'b00;
            if (accept) begin
              state <= EXEC;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU drives alu_result, a transaction-level model
// predicts every output each cycle, and directed sequences pin hand-computed values.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  alu_aluop;
  logic [6:0]  alu_fun7;
  logic [2:0]  alu_fun3;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        busy;

  int n_cmp;
  int n_err;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .alu_aluop(alu_aluop), .alu_fun7(alu_fun7), .alu_fun3(alu_fun3),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {ALUOp, fun7, fun3}
  function automatic logic [31:0] alu_fn(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op[11:10])
      2'b00: return a + b;
      2'b01: return a - b;
      default: begin
        case (op[2:0])
          3'd0:    return op[8] ? (a - b) : (a + b);
          3'd4:    return a ^ b;
          3'd6:    return a | b;
          3'd7:    return a & b;
          default: return a + b;
        endcase
      end
    endcase
  endfunction

  assign alu_result = alu_fn({alu_aluop, alu_fun7, alu_fun3}, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- transaction-level model ----------------
  // An in-flight op is tracked by its age in cycles since accept: age 1 = on the ALU,
  // age >= 2 = response offered to its owner.
  logic        m_pend;
  int          m_age;
  logic        m_owner;
  logic        m_last;
  logic [11:0] m_op;
  logic [31:0] m_a, m_b, m_res;
  logic        m_zero;
  logic [1:0]  e_ready;
  logic        w;
  logic        may, exec_ph, resp_ph;

  initial begin
    m_pend = 1'b0; m_age = 0; m_owner = 1'b0; m_last = 1'b1;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_zero = 1'b0;
    forever begin
      @(negedge clk);
      exec_ph = m_pend && (m_age == 1);
      resp_ph = m_pend && (m_age >= 2);
      may     = !m_pend || (resp_ph && rsp_ready[m_owner]);
      w       = 1'b0;
      if (req_valid == 2'b10) w = 1'b1;
      else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w = 1'b0;
`else
        w = (m_last == 1'b0);
`endif
      end
      e_ready = (may && req_valid != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;

      chk("model_req_ready", {30'd0, req_ready}, {30'd0, e_ready});
      chk("model_alu_op", {20'd0, alu_aluop, alu_fun7, alu_fun3}, exec_ph ? {20'd0, m_op} : 32'd0);
      chk("model_alu_a", alu_a, exec_ph ? m_a : 32'd0);
      chk("model_alu_b", alu_b, exec_ph ? m_b : 32'd0);
      chk("model_rsp_valid", {30'd0, rsp_valid}, resp_ph ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
      chk("model_rsp_result", rsp_result, m_res);
      chk("model_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
      chk("model_busy", {31'd0, busy}, {31'd0, m_pend});

      if (reset) begin
        m_pend = 1'b0; m_last = 1'b1; m_res = '0; m_zero = 1'b0;
      end else begin
        if (exec_ph) begin
          m_res  = alu_fn(m_op, m_a, m_b);
          m_zero = (m_res == 32'd0);
        end
        if (resp_ph && rsp_ready[m_owner]) m_pend = 1'b0;
        else if (m_pend) m_age++;
        if (e_ready != 2'b00) begin
          m_pend  = 1'b1;
          m_age   = 1;
          m_owner = w;
          m_last  = w;
          m_op    = w ? req1_op : req0_op;
          m_a     = w ? req1_a  : req0_a;
          m_b     = w ? req1_b  : req0_b;
        end
      end
    end
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  int order [4];
  int ng;
  int cyc;
  bit saw1;

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_op", {20'd0, alu_aluop, alu_fun7, alu_fun3}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);

    // Single op: 5 + 7
    step();
    req_valid = 2'b01; req0_op = 12'h000; req0_a = 32'd5; req0_b = 32'd7; rsp_ready = 2'b11;
    @(negedge clk);
    chk("single_req_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_alu_a", alu_a, 32'd5);
    chk("single_alu_b", alu_b, 32'd7);
    chk("single_busy", {31'd0, busy}, 32'd1);
    step();
    @(negedge clk);
    chk("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("single_rsp_result", rsp_result, 32'd12);
    chk("single_alu_a_cleared", alu_a, 32'd0);
    step();
    @(negedge clk);
    chk("single_rsp_dropped", {30'd0, rsp_valid}, 32'd0);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Contention from reset: req0 ADD 1+2, req1 SUB 10-10
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    req0_op = 12'h000; req0_a = 32'd1;  req0_b = 32'd2;
    req1_op = 12'h400; req1_a = 32'd10; req1_b = 32'd10;
    ng = 0; cyc = 0; saw1 = 1'b0;
    while (ng < 4 && cyc < 40) begin
      @(negedge clk);
      if (req_ready[0]) begin order[ng] = 0; ng++; end
      else if (req_ready[1]) begin order[ng] = 1; ng++; end
      if (rsp_valid[1]) begin
        saw1 = 1'b1;
        chk("sub_rsp_zero", {31'd0, rsp_zero}, 32'd1);
        chk("sub_rsp_result", rsp_result, 32'd0);
      end
      cyc++;
    end
    step();
    req_valid = 2'b00;
    chk("contention_grant_count", ng, 32'd4);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("prio_grant0", order[0], 32'd0);
    chk("prio_grant1", order[1], 32'd0);
    chk("prio_grant2", order[2], 32'd0);
    chk("prio_grant3", order[3], 32'd0);
`else
    chk("rr_grant0", order[0], 32'd0);
    chk("rr_grant1", order[1], 32'd1);
    chk("rr_grant2", order[2], 32'd0);
    chk("rr_grant3", order[3], 32'd1);
    chk("rr_req1_responded", {31'd0, saw1}, 32'd1);
`endif
    wait_idle("contention_drain");

    // Backpressure: AND 0xF0F0 & 0xFF00, response stalled 5 cycles
    step();
    req_valid = 2'b01; req0_op = 12'h807; req0_a = 32'h0000_F0F0; req0_b = 32'h0000_FF00; rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_req_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b10; req1_op = 12'h000; req1_a = 32'd1; req1_b = 32'd1; rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_exec_no_ready", {30'd0, req_ready}, 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid_held", {30'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_result_held", rsp_result, 32'h0000_F000);
      chk("bp_req_ready_low", {30'd0, req_ready}, 32'd0);
      step();
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_release_valid", {30'd0, rsp_valid}, 32'd1);
    step();
    @(negedge clk);
    chk("bp_release_idle", {31'd0, busy}, 32'd0);
    chk("bp_release_rsp_low", {30'd0, rsp_valid}, 32'd0);

    // Back-to-back: req0 ADD 100+23, req1 XOR 0xFF^0x0F accepted on req0's handshake
    step();
    req_valid = 2'b01; req0_op = 12'h000; req0_a = 32'd100; req0_b = 32'd23; rsp_ready = 2'b00;
    @(negedge clk);
    chk("b2b_req0_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b10; req1_op = 12'h804; req1_a = 32'h0000_00FF; req1_b = 32'h0000_000F;
    @(negedge clk);
    chk("b2b_exec_no_ready", {30'd0, req_ready}, 32'd0);
    step();
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("b2b_rsp0_valid", {30'd0, rsp_valid}, 32'd1);
    chk("b2b_rsp0_result", rsp_result, 32'd123);
    chk("b2b_req1_ready_same_cycle", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clk);
    chk("b2b_exec1_rsp_low", {30'd0, rsp_valid}, 32'd0);
    chk("b2b_exec1_alu_a", alu_a, 32'h0000_00FF);
    step();
    @(negedge clk);
    chk("b2b_rsp1_valid", {30'd0, rsp_valid}, 32'd2);
    chk("b2b_rsp1_result", rsp_result, 32'h0000_00F0);
    step();
    rsp_ready = 2'b11;
    wait_idle("b2b_drain");

    // Reset during EXEC discards the op and restores requester 0 priority
    step();
    req_valid = 2'b01; req0_op = 12'h400; req0_a = 32'd9; req0_b = 32'd4;
    @(negedge clk);
    chk("rx_req_ready", {30'd0, req_ready}, 32'd1);
    step();
    reset = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    chk("rx_exec_busy", {31'd0, busy}, 32'd1);
    step();
    reset = 1'b0; req_valid = 2'b11;
    req0_op = 12'h000; req0_a = 32'd2; req0_b = 32'd3;
    req1_op = 12'h000; req1_a = 32'd4; req1_b = 32'd4;
    @(negedge clk);
    chk("rx_no_rsp", {30'd0, rsp_valid}, 32'd0);
    chk("rx_busy_low", {31'd0, busy}, 32'd0);
    chk("rx_alu_a_zero", alu_a, 32'd0);
    chk("rx_alu_op_zero", {20'd0, alu_aluop, alu_fun7, alu_fun3}, 32'd0);
    chk("rx_rsp_result_zero", rsp_result, 32'd0);
    chk("rx_grant_req0", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    wait_idle("rx_drain");
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates one shared ALU + ALU control path between two requesters (0: integer datapath, 1: address/branch-compare helper). It latches the granted operation, drives the shared ALU inputs for one execute cycle, and captures the result. The result is returned over a valid/ready response channel to the requester that issued it. It sits between the requesters and the existing combinational ALU control/ALU pair, with one request in flight at a time.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request valid (bit n = requester n)
- req_ready  out  2  per-requester accept; at most one bit set; combinational
- req0_op, req1_op  in  12  {ALUOp[1:0], fun7[6:0], fun3[2:0]}
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands
- alu_aluop  out  2  to shared ALU control
- alu_fun7  out  7  to shared ALU control
- alu_fun3  out  3  to shared ALU control
- alu_a, alu_b  out  WIDTH  to shared ALU
- alu_result  in  WIDTH  from shared ALU (combinational, same cycle)
- alu_zero  in  1  from shared ALU
- rsp_valid  out  2  response valid, one-hot or zero, to the issuing requester
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  WIDTH  registered result
- rsp_zero  out  1  registered zero flag
- busy  out  1  high in EXEC or RESP

## Operation
- FSM states:
  - IDLE -> EXEC: on accept.
  - EXEC -> RESP: always, after 1 cycle.
  - RESP -> IDLE: on response handshake with no new accept.
  - RESP -> EXEC: on response handshake with a same-cycle accept.
- Accept: req_valid[g] & req_ready[g]. Permitted in IDLE, or in RESP in the cycle rsp_valid[g'] & rsp_ready[g'] completes. Never permitted in EXEC.
- Grant (default): round-robin.
  - Register last_grant; reset value 1, so requester 0 wins first.
  - Both valid: grant !last_grant.
  - One valid: grant that one.
  - last_grant updates only on accept.
- On accept: latch op, a, b and owner id g into internal registers.
- EXEC: alu_aluop/fun7/fun3/a/b driven from the latched registers. At the end of the cycle, alu_result and alu_zero are captured into rsp_result and rsp_zero.
- Outside EXEC: ALU outputs are driven to 0 (op 00_0000000_000, operands 0).
- RESP: rsp_valid[owner] = 1 and is held with rsp_result/rsp_zero stable until rsp_ready[owner]. rsp_ready of the non-owner is ignored.
- The arbiter does not inspect op encodings; an illegal op passes through and returns whatever the ALU produces.

## Timing
- Reset values:
  - state IDLE, last_grant 1
  - req_ready 0, rsp_valid 0, rsp_result 0, rsp_zero 0, busy 0
  - all alu_* outputs 0
- Latency: accept at cycle T -> EXEC at T+1 -> rsp_valid high from T+2.
- Minimum response-to-response spacing is 2 cycles (back-to-back accept in RESP).
- req_ready is combinational from state, req_valid, last_grant and (in RESP) rsp_ready.
- Requesters must hold req_*_op/a/b stable while valid and not accepted.
- Response stall: rsp_ready low holds RESP indefinitely; req_ready stays 0 for both requesters.
- Simultaneous request and response handshake by the same requester in RESP is legal; the new op enters EXEC the next cycle.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is produced, and last_grant returns to 1.
- busy is high in EXEC and RESP, low in IDLE.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins when both are valid. last_grant is still maintained but not used for selection.
  - Undefined: round-robin as described in Operation.

## Test plan
- Single op: reset; req0 op 00_0000000_000, a=5, b=7 -> req_ready[0] same cycle; alu_a=5, alu_b=7 at T+1; rsp_valid[0], rsp_result=12 at T+2; alu_* = 0 at T+2.
- Contention, round-robin: both valid from reset -> grant order 0,1,0,1. SUB 10-10 on req1 returns rsp_zero=1.
- Contention with ALU_ARB_FIXED_PRIO_EN defined: both continuously valid -> requester 0 granted every time; req1 never granted.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles -> rsp_valid[0] and rsp_result stable; req_ready=0 throughout; release -> IDLE.
- Back-to-back: rsp_ready[0]=1 while req1 valid in RESP -> req_ready[1] in the same cycle; next rsp_valid[1] arrives 2 cycles later.
- Reset during EXEC: assert reset for 1 cycle -> no rsp_valid; all outputs 0 next cycle; next grant goes to requester 0.
